sprite_pos_tracker: RTL and testbench

- Parametrised single-axis position register for one on-screen object: enemy x, main player x, or a left/right hand y.
- Replaces the fixed-width per-object trackers.
- Adds frame-rate-limited stepping, saturating or wrapping bounds, direct load, and an autonomous punch stroke FSM: extend, hold, retract to origin.
- Outputs feed the draw/erase logic that drives vga_adapter x/y (160x120).

---
 rtl/sprite_pos_tracker.sv | 162 ++++++++++++++++
 tb/tb_sprite_pos_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_pos_tracker.sv
// Single-axis position register for one sprite: tick-rate stepping, clamp/wrap
// bounds, direct load, and an autonomous extend/hold/retract punch stroke.
module sprite_pos_tracker #(
  parameter int WIDTH      = 8,
  parameter int MIN        = 0,
  parameter int MAX        = 159,
  parameter int HOME       = 80,
  parameter int STEP       = 1,
  parameter int TICK_DIV   = 833333,
  parameter int PUNCH_LEN  = 16,
  parameter int HOLD_TICKS = 4,
  parameter bit WRAP       = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             move_inc,
  input  logic             move_dec,
  input  logic             punch,
  input  logic             punch_dir,
  output logic [WIDTH-1:0] pos,
  output logic             tick,
  output logic             busy,
  output logic             punch_done,
  output logic             at_min,
  output logic             at_max
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HC_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int TR_W  = $clog2(PUNCH_LEN + STEP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLD_TICKS - 1);
  localparam logic [TR_W-1:0]  TR_STEP  = TR_W'(STEP);
  localparam logic [TR_W-1:0]  TR_LEN   = TR_W'(PUNCH_LEN);
  localparam logic [WIDTH:0]   MIN_E    = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   MAX_E    = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_E   = (WIDTH+1)'(STEP);

  typedef enum logic [1:0] {IDLE, EXTEND, HOLD, RETRACT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d, origin_q, origin_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [TR_W-1:0]  trav_q, trav_d;
  logic             dir_q, dir_d, done_q, done_d;
  logic [WIDTH:0]   pos_e, org_e, nxt;

  // All stepping is done one bit wider so overflow past MAX stays visible.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH:0] p, input logic wr);
    logic [WIDTH:0] s;
    s = p + STEP_E;
    if (s > MAX_E) return wr ? MIN_E : MAX_E;
    return s;
  endfunction

  function automatic logic [WIDTH:0] step_dn(input logic [WIDTH:0] p, input logic wr);
    if (p < MIN_E + STEP_E) return wr ? MAX_E : MIN_E;
    return p - STEP_E;
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] e;
    e = {1'b0, v};
    if (e < MIN_E) return MIN_E[WIDTH-1:0];
    if (e > MAX_E) return MAX_E[WIDTH-1:0];
    return v;
  endfunction

  assign pos_e = {1'b0, pos_q};
  assign org_e = {1'b0, origin_q};
  assign tick  = enable && (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    origin_d = origin_q;
    dir_d    = dir_q;
    trav_d   = trav_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    nxt      = pos_e;
    div_d    = div_q;
    if (enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    if (load) begin
      pos_d   = clamp(load_val);
      state_d = IDLE;
      trav_d  = '0;
      hold_d  = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (punch) begin
            origin_d = pos_q;
            dir_d    = punch_dir;
            trav_d   = '0;
            state_d  = EXTEND;
          end else if (move_inc ^ move_dec) begin
            nxt   = move_inc ? step_up(pos_e, WRAP) : step_dn(pos_e, WRAP);
            pos_d = nxt[WIDTH-1:0];
          end
        end
        EXTEND: begin
          nxt    = dir_q ? step_up(pos_e, 1'b0) : step_dn(pos_e, 1'b0);
          pos_d  = nxt[WIDTH-1:0];
          trav_d = trav_q + TR_STEP;
          if (trav_d >= TR_LEN || nxt == (dir_q ? MAX_E : MIN_E)) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          if (hold_q == HC_LAST) state_d = RETRACT;
          else hold_d = hold_q + 1'b1;
        end
        RETRACT: begin
          // Snap to origin rather than overshoot when less than a step remains.
          if (pos_e > org_e) nxt = (pos_e - org_e <= STEP_E) ? org_e : pos_e - STEP_E;
          else               nxt = (org_e - pos_e <= STEP_E) ? org_e : pos_e + STEP_E;
          pos_d = nxt[WIDTH-1:0];
          if (nxt == org_e) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pos_q    <= WIDTH'(HOME);
      origin_q <= WIDTH'(HOME);
      div_q    <= '0;
      hold_q   <= '0;
      trav_q   <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      origin_q <= origin_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      trav_q   <= trav_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
    end
  end

  assign pos        = pos_q;
  assign busy       = (state_q != IDLE);
  assign punch_done = done_q;
  assign at_min     = (pos_q == WIDTH'(MIN));
  assign at_max     = (pos_q == WIDTH'(MAX));
endmodule

// File: tb/tb_sprite_pos_tracker.sv
// Directed bench for sprite_pos_tracker: a saturating and a wrapping instance
// share stimulus; a vector table covers stepping and strokes, hand sequences the rest.
module tb_sprite_pos_tracker;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, load = 1'b0, move_inc = 1'b0, move_dec = 1'b0;
  logic       punch = 1'b0, punch_dir = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] pos, wpos;
  logic       tick, busy, done, amin, amax;
  logic       wtick, wbusy, wdone, wamin, wamax;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sprite_pos_tracker #(.WIDTH(8), .MIN(0), .MAX(159), .HOME(80), .STEP(1), .TICK_DIV(4),
    .PUNCH_LEN(4), .HOLD_TICKS(2), .WRAP(1'b0)) u_sat (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load), .load_val(load_val),
    .move_inc(move_inc), .move_dec(move_dec), .punch(punch), .punch_dir(punch_dir),
    .pos(pos), .tick(tick), .busy(busy), .punch_done(done), .at_min(amin), .at_max(amax));

  sprite_pos_tracker #(.WIDTH(8), .MIN(0), .MAX(159), .HOME(80), .STEP(1), .TICK_DIV(4),
    .PUNCH_LEN(4), .HOLD_TICKS(2), .WRAP(1'b1)) u_wrap (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load), .load_val(load_val),
    .move_inc(move_inc), .move_dec(move_dec), .punch(punch), .punch_dir(punch_dir),
    .pos(wpos), .tick(wtick), .busy(wbusy), .punch_done(wdone), .at_min(wamin), .at_max(wamax));

  typedef struct {
    logic ld; int lv; logic inc, dec, pch, dir;
    int pos, wpos; logic busy, amin, amax, done;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for a tick cycle (inputs already set), let its edge land, sample 1 ns later.
  task automatic do_tick();
    int n = 0;
    @(negedge clock);
    while (!tick && n < 16) begin
      @(negedge clock);
      n++;
    end
    if (!tick) begin
      failures++; checks++;
      $display("FAIL tick_timeout: got no tick expected tick within 16 cycles");
    end
    @(posedge clock); #1;
  endtask

  task automatic do_load(input int v);
    move_inc = 0; move_dec = 0; punch = 0;
    load = 1; load_val = 8'(v);
    @(posedge clock); #1;
    load = 0;
  endtask

  task automatic add(input logic ld, input int lv, input logic inc, input logic dec,
                     input logic pch, input logic dir, input int p, input int wp,
                     input logic b, input logic mn, input logic mx, input logic dn);
    vq.push_back('{ld, lv, inc, dec, pch, dir, p, wp, b, mn, mx, dn});
  endtask

  initial begin
    int t, cnt;
    //   ld lv  inc dec pch dir  pos wpos busy min max done
    add(0, 0,   1, 0, 0, 0,  81,  81, 0, 0, 0, 0);
    add(0, 0,   1, 0, 0, 0,  82,  82, 0, 0, 0, 0);
    add(0, 0,   1, 0, 0, 0,  83,  83, 0, 0, 0, 0);
    add(0, 0,   1, 1, 0, 0,  83,  83, 0, 0, 0, 0);
    add(0, 0,   0, 1, 0, 0,  82,  82, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0,  82,  82, 0, 0, 0, 0);
    add(1, 200, 0, 0, 0, 0, 159, 159, 0, 0, 1, 0);
    add(0, 0,   1, 0, 0, 0, 159,   0, 0, 0, 1, 0);
    add(0, 0,   1, 0, 0, 0, 159,   1, 0, 0, 1, 0);
    add(1, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0, 0);
    add(0, 0,   0, 1, 0, 0,   0, 159, 0, 1, 0, 0);
    add(1, 80,  0, 0, 0, 0,  80,  80, 0, 0, 0, 0);
    // full stroke toward MAX; move_inc held to show it is ignored
    add(0, 0,   0, 0, 1, 1,  80,  80, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  81,  81, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  82,  82, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  83,  83, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  84,  84, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  84,  84, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  84,  84, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  83,  83, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  82,  82, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  81,  81, 1, 0, 0, 0);
    add(0, 0,   1, 0, 0, 1,  80,  80, 0, 0, 0, 1);
    // short stroke cut by MAX
    add(1, 157, 0, 0, 0, 0, 157, 157, 0, 0, 0, 0);
    add(0, 0,   0, 0, 1, 1, 157, 157, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 1, 158, 158, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 1, 159, 159, 1, 0, 1, 0);
    add(0, 0,   0, 0, 0, 1, 159, 159, 1, 0, 1, 0);
    add(0, 0,   0, 0, 0, 1, 159, 159, 1, 0, 1, 0);
    add(0, 0,   0, 0, 0, 1, 158, 158, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 1, 157, 157, 0, 0, 0, 1);
    // short stroke cut by MIN, even on the wrapping instance
    add(1, 2,   0, 0, 0, 0,   2,   2, 0, 0, 0, 0);
    add(0, 0,   0, 0, 1, 0,   2,   2, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0,   1,   1, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0,   0,   0, 1, 1, 0, 0);
    add(0, 0,   0, 0, 0, 0,   0,   0, 1, 1, 0, 0);
    add(0, 0,   0, 0, 0, 0,   0,   0, 1, 1, 0, 0);
    add(0, 0,   0, 0, 0, 0,   1,   1, 1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0,   2,   2, 0, 0, 0, 1);

    // reset state
    #12;
    chk("rst_pos", pos, 80);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_minmax", {amin, amax}, 0);

    // tick spacing
    @(negedge clock); reset_n = 1; enable = 1;
    cnt = 0;
    while (!tick && cnt < 16) begin @(negedge clock); cnt++; end
    chk("first_tick_cycles", cnt, 3);
    cnt = 0;
    @(negedge clock); cnt++;
    while (!tick && cnt < 16) begin @(negedge clock); cnt++; end
    chk("tick_period", cnt, 4);
    chk("idle_pos", pos, 80);
    @(posedge clock); #1;

    foreach (vq[i]) begin
      if (vq[i].ld) do_load(vq[i].lv);
      else begin
        move_inc = vq[i].inc; move_dec = vq[i].dec;
        punch = vq[i].pch; punch_dir = vq[i].dir;
        do_tick();
      end
      chk($sformatf("v%0d_pos", i), pos, vq[i].pos);
      chk($sformatf("v%0d_wpos", i), wpos, vq[i].wpos);
      chk($sformatf("v%0d_busy", i), busy, vq[i].busy);
      chk($sformatf("v%0d_min", i), amin, vq[i].amin);
      chk($sformatf("v%0d_max", i), amax, vq[i].amax);
      chk($sformatf("v%0d_done", i), done, vq[i].done);
    end

    // load aborts a stroke mid-EXTEND
    do_load(80);
    move_inc = 0; punch = 1; punch_dir = 1; do_tick();
    punch = 0; do_tick(); do_tick();
    chk("abort_pre_pos", pos, 82);
    do_load(40);
    chk("abort_pos", pos, 40);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    do_tick();
    chk("abort_after_pos", pos, 40);
    chk("abort_after_done", done, 0);

    // async reset mid-HOLD
    do_load(80);
    punch = 1; punch_dir = 1; do_tick();
    punch = 0;
    repeat (5) do_tick();
    chk("hold_pos", pos, 84);
    #2 reset_n = 0;
    #1;
    chk("async_rst_pos", pos, 80);
    chk("async_rst_busy", busy, 0);

    // enable freeze
    @(negedge clock); reset_n = 1; enable = 1;
    @(posedge clock); @(posedge clock);
    @(negedge clock); enable = 0; move_inc = 1;
    t = 0;
    repeat (20) begin
      @(negedge clock);
      if (tick) t++;
    end
    chk("frozen_ticks", t, 0);
    chk("frozen_pos", pos, 80);
    enable = 1;
    cnt = 0;
    while (!tick && cnt < 16) begin @(negedge clock); cnt++; end
    chk("resume_tick_cycles", cnt, 1);
    @(posedge clock); #1;
    chk("resume_pos", pos, 81);
    move_inc = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
